// File: rtl/dbg_boot_sequencer.sv
// Boots a halted-image hart over DMI: activates the debug module, halts the
// selected hart, writes DPC through an abstract command, then resumes it.
module dbg_boot_sequencer #(
    parameter logic [31:0] BootAddr    = 32'h8000_0080,
    parameter logic [9:0]  HartSel     = 10'd0,
    parameter int unsigned PollTimeout = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    output logic [6:0]  dmi_req_addr_o,
    output logic [1:0]  dmi_req_op_o,
    output logic [31:0] dmi_req_data_o,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o,
    input  logic [31:0] dmi_resp_data_i,
    input  logic [1:0]  dmi_resp_resp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [3:0]  err_step_o
);

    localparam int unsigned StepW   = 4;
    localparam int unsigned PollW   = (PollTimeout < 2) ? 1 : $clog2(PollTimeout);
    localparam int unsigned ReqW    = 7 + 2 + 32;

    localparam logic [6:0] AddrData0   = 7'h04;
    localparam logic [6:0] AddrDmctl   = 7'h10;
    localparam logic [6:0] AddrDmstat  = 7'h11;
    localparam logic [6:0] AddrAbscs   = 7'h16;
    localparam logic [6:0] AddrCommand = 7'h17;

    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;

    localparam logic [31:0] HartField   = {6'd0, HartSel, 16'd0};
    localparam logic [31:0] DmActive    = 32'h0000_0001;
    localparam logic [31:0] HaltReq     = 32'h8000_0000;
    localparam logic [31:0] ResumeReq   = 32'h4000_0000;
    localparam logic [31:0] CmdWriteDpc = 32'h0023_07B1;

    localparam logic [31:0] MaskAllHalted    = 32'h0000_0200;
    localparam logic [31:0] MaskAbsBusy      = 32'h0000_1000;
    localparam logic [31:0] MaskCmdErr       = 32'h0000_0700;
    localparam logic [31:0] MaskAllResumeAck = 32'h0002_0000;

    localparam logic [StepW-1:0] StepWaitHalt   = StepW'(3);
    localparam logic [StepW-1:0] StepWaitAbs    = StepW'(7);
    localparam logic [StepW-1:0] StepWaitResume = StepW'(9);

    localparam logic [PollW-1:0] PollLast = PollW'(PollTimeout - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StResp,
        StDone,
        StError
    } state_e;

    state_e             state_q, state_d;
    logic [StepW-1:0]   step_q, step_d;
    logic [PollW-1:0]   poll_cnt_q, poll_cnt_d;
    logic               req_valid_q, req_valid_d;
    logic [6:0]         req_addr_q, req_addr_d;
    logic [1:0]         req_op_q, req_op_d;
    logic [31:0]        req_data_q, req_data_d;
    logic               resp_ready_q, resp_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [3:0]         err_step_q, err_step_d;

    logic               is_poll_step;
    logic               poll_ok;
    logic               cmderr_set;
    logic               abort;
    logic [ReqW-1:0]    step_req;

    // Fixed request for each step, packed as {addr, op, data}.
    function automatic logic [ReqW-1:0] req_for_step(input logic [StepW-1:0] step);
        logic [ReqW-1:0] r;
        r = {AddrDmctl, OpWrite, DmActive};
        case (step)
            4'd0:    r = {AddrDmctl,   OpWrite, DmActive};
            4'd1:    r = {AddrDmctl,   OpWrite, HartField | DmActive};
            4'd2:    r = {AddrDmctl,   OpWrite, HartField | HaltReq | DmActive};
            4'd3:    r = {AddrDmstat,  OpRead,  32'd0};
            4'd4:    r = {AddrDmctl,   OpWrite, HartField | DmActive};
            4'd5:    r = {AddrData0,   OpWrite, BootAddr};
            4'd6:    r = {AddrCommand, OpWrite, CmdWriteDpc};
            4'd7:    r = {AddrAbscs,   OpRead,  32'd0};
            4'd8:    r = {AddrDmctl,   OpWrite, HartField | ResumeReq | DmActive};
            4'd9:    r = {AddrDmstat,  OpRead,  32'd0};
            default: r = {AddrDmctl,   OpWrite, DmActive};
        endcase
        return r;
    endfunction

    // Evaluate the read data of the current step's response.
    always_comb begin
        is_poll_step = 1'b0;
        poll_ok      = 1'b1;
        cmderr_set   = (dmi_resp_data_i & MaskCmdErr) != 32'd0;
        case (step_q)
            StepWaitHalt: begin
                is_poll_step = 1'b1;
                poll_ok      = (dmi_resp_data_i & MaskAllHalted) != 32'd0;
            end
            StepWaitAbs: begin
                is_poll_step = 1'b1;
                poll_ok      = (dmi_resp_data_i & MaskAbsBusy) == 32'd0;
            end
            StepWaitResume: begin
                is_poll_step = 1'b1;
                poll_ok      = (dmi_resp_data_i & MaskAllResumeAck) != 32'd0;
            end
            default: begin
                is_poll_step = 1'b0;
                poll_ok      = 1'b1;
            end
        endcase
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        poll_cnt_d = poll_cnt_q;
        done_d     = done_q;
        error_d    = error_q;
        err_step_d = err_step_q;
        abort      = 1'b0;
        req_addr_d = req_addr_q;
        req_op_d   = req_op_q;
        req_data_d = req_data_q;
        step_req   = '0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d    = StReq;
                    step_d     = '0;
                    poll_cnt_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_step_d = 4'd0;
                end
            end
            StReq: begin
                // Valid is always high here, so ready alone completes the handshake.
                if (dmi_req_ready_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (dmi_resp_valid_i) begin
                    if (dmi_resp_resp_i != 2'd0) begin
                        abort = 1'b1;
                    end else if (is_poll_step && !poll_ok) begin
                        if (poll_cnt_q == PollLast) begin
                            abort = 1'b1;
                        end else begin
                            poll_cnt_d = poll_cnt_q + PollW'(1);
                            state_d    = StReq;
                        end
                    end else if (step_q == StepWaitAbs && cmderr_set) begin
                        abort = 1'b1;
                    end else if (step_q == StepWaitResume) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        step_d     = step_q + StepW'(1);
                        poll_cnt_d = '0;
                        state_d    = StReq;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort) begin
            state_d    = StError;
            error_d    = 1'b1;
            err_step_d = step_q;
        end

        if (state_d == StReq) begin
            step_req   = req_for_step(step_d);
            req_addr_d = step_req[ReqW-1 -: 7];
            req_op_d   = step_req[33:32];
            req_data_d = step_req[31:0];
        end

        req_valid_d  = (state_d == StReq);
        busy_d       = (state_d == StReq) || (state_d == StResp);
        resp_ready_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            step_q       <= '0;
            poll_cnt_q   <= '0;
            req_valid_q  <= 1'b0;
            req_addr_q   <= 7'd0;
            req_op_q     <= 2'd0;
            req_data_q   <= 32'd0;
            resp_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_step_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            poll_cnt_q   <= poll_cnt_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_op_q     <= req_op_d;
            req_data_q   <= req_data_d;
            resp_ready_q <= resp_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_step_q   <= err_step_d;
        end
    end

    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = req_addr_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_req_data_o   = req_data_q;
    assign dmi_resp_ready_o = resp_ready_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign err_step_o       = err_step_q;

endmodule

// File: tb/tb_dbg_boot_sequencer.sv
// Bench for dbg_boot_sequencer: a DMI responder serves a scoreboard of
// expected transactions for a table of scenarios plus reset corner cases.
module tb_dbg_boot_sequencer;

    localparam int unsigned PT      = 8;
    localparam logic [9:0]  HART    = 10'h2A5;
    localparam logic [31:0] BOOT    = 32'h8000_0080;
    localparam logic [31:0] H       = {6'd0, HART, 16'd0};
    localparam int          NO_STEP = 15;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i;
    logic [6:0]  dmi_req_addr_o;
    logic [1:0]  dmi_req_op_o;
    logic [31:0] dmi_req_data_o;
    logic        dmi_resp_valid_i;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i;
    logic [1:0]  dmi_resp_resp_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [3:0]  err_step_o;

    dbg_boot_sequencer #(
        .BootAddr   (BOOT),
        .HartSel    (HART),
        .PollTimeout(PT)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .dmi_req_valid_o (dmi_req_valid_o),
        .dmi_req_ready_i (dmi_req_ready_i),
        .dmi_req_addr_o  (dmi_req_addr_o),
        .dmi_req_op_o    (dmi_req_op_o),
        .dmi_req_data_o  (dmi_req_data_o),
        .dmi_resp_valid_i(dmi_resp_valid_i),
        .dmi_resp_ready_o(dmi_resp_ready_o),
        .dmi_resp_data_i (dmi_resp_data_i),
        .dmi_resp_resp_i (dmi_resp_resp_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .error_o         (error_o),
        .err_step_o      (err_step_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          step;
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } txn_t;

    typedef struct {
        int halt_fail;
        int abs_busy;
        int cmderr;
        int ack_fail;
        int err_step;
        int stall_step;
        int stall_cyc;
        bit exp_done;
        bit exp_error;
        int exp_err_step;
    } scen_t;

    txn_t  exp_q[$];
    scen_t tbl[10];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cur_stall_step = NO_STEP;
    int    cur_stall_cyc  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Transaction-level model of the boot flow for one scenario.
    task automatic build_expected(input scen_t s);
        exp_q.delete();
        for (int st = 0; st < 10; st++) begin
            int  fails;
            int  reads;
            bit  poll;
            fails = (st == 3) ? s.halt_fail : (st == 7) ? s.abs_busy : (st == 9) ? s.ack_fail : 0;
            poll  = (st == 3) || (st == 7) || (st == 9);
            reads = 0;
            forever begin
                txn_t t;
                t.step  = st;
                t.op    = 2'd2;
                t.wdata = 32'd0;
                t.rdata = $urandom;
                case (st)
                    0: begin t.addr = 7'h10; t.wdata = 32'h0000_0001; end
                    1: begin t.addr = 7'h10; t.wdata = H | 32'h0000_0001; end
                    2: begin t.addr = 7'h10; t.wdata = H | 32'h8000_0001; end
                    3: begin t.addr = 7'h11; t.op = 2'd1; end
                    4: begin t.addr = 7'h10; t.wdata = H | 32'h0000_0001; end
                    5: begin t.addr = 7'h04; t.wdata = BOOT; end
                    6: begin t.addr = 7'h17; t.wdata = 32'h0023_07B1; end
                    7: begin t.addr = 7'h16; t.op = 2'd1; end
                    8: begin t.addr = 7'h10; t.wdata = H | 32'h4000_0001; end
                    default: begin t.addr = 7'h11; t.op = 2'd1; end
                endcase
                reads++;
                if (st == 3) t.rdata = (reads > fails) ? (t.rdata | 32'h200) : (t.rdata & ~32'h200);
                if (st == 9) t.rdata = (reads > fails) ? (t.rdata | 32'h20000) : (t.rdata & ~32'h20000);
                if (st == 7) t.rdata = (reads > fails)
                    ? ((t.rdata & ~32'h1700) | (32'(s.cmderr) << 8)) : (t.rdata | 32'h1000);
                t.resp = (st == s.err_step) ? 2'd2 : 2'd0;
                exp_q.push_back(t);
                if (t.resp != 2'd0) return;
                if (!poll || reads > fails) break;
                if (reads == int'(PT)) return;
            end
            if (st == 7 && s.cmderr != 0) return;
        end
    endtask

    task automatic serve_req(output bit ok, output txn_t t);
        int w;
        int stall;
        logic [6:0]  a0;
        logic [31:0] d0;
        ok = 1'b0;
        t  = '{default: 0};
        w  = 0;
        while (!dmi_req_valid_o && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (!dmi_req_valid_o) begin
            chk("req_timeout", 32'(dmi_req_valid_o), 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_req", 32'(exp_q.size()), 32'd1);
            return;
        end
        t = exp_q.pop_front();
        chk($sformatf("s%0d_addr", t.step), 32'(dmi_req_addr_o), 32'(t.addr));
        chk($sformatf("s%0d_op", t.step), 32'(dmi_req_op_o), 32'(t.op));
        if (t.op == 2'd2) chk($sformatf("s%0d_wdata", t.step), dmi_req_data_o, t.wdata);
        stall = (t.step == cur_stall_step) ? cur_stall_cyc : 0;
        a0 = dmi_req_addr_o;
        d0 = dmi_req_data_o;
        for (int i = 0; i < stall; i++) begin
            start_i = 1'b1;
            @(negedge clk);
            chk("stall_valid", 32'(dmi_req_valid_o), 32'd1);
            chk("stall_addr", 32'(dmi_req_addr_o), 32'(a0));
            chk("stall_data", dmi_req_data_o, d0);
        end
        start_i = 1'b0;
        dmi_req_ready_i = 1'b1;
        @(negedge clk);
        dmi_req_ready_i = 1'b0;
        chk("valid_drop", 32'(dmi_req_valid_o), 32'd0);
        ok = 1'b1;
    endtask

    task automatic serve_resp(input txn_t t);
        chk("resp_ready", 32'(dmi_resp_ready_o), 32'd1);
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = t.rdata;
        dmi_resp_resp_i  = t.resp;
        @(negedge clk);
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = 32'd0;
        dmi_resp_resp_i  = 2'd0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        chk("start_busy", 32'(busy_o), 32'd1);
        chk("start_valid", 32'(dmi_req_valid_o), 32'd1);
        chk("start_done_clr", 32'(done_o), 32'd0);
        chk("start_err_clr", 32'(error_o), 32'd0);
        chk("start_step_clr", 32'(err_step_o), 32'd0);
    endtask

    task automatic run_scenario(input int idx);
        scen_t s;
        txn_t  t;
        bit    ok;
        int    extra;
        s = tbl[idx];
        cur_stall_step = s.stall_step;
        cur_stall_cyc  = s.stall_cyc;
        build_expected(s);
        pulse_start();
        while (exp_q.size() > 0) begin
            serve_req(ok, t);
            if (!ok) break;
            serve_resp(t);
        end
        chk($sformatf("sc%0d_left", idx), 32'(exp_q.size()), 32'd0);
        chk($sformatf("sc%0d_busy", idx), 32'(busy_o), 32'd0);
        chk($sformatf("sc%0d_done", idx), 32'(done_o), 32'(s.exp_done));
        chk($sformatf("sc%0d_error", idx), 32'(error_o), 32'(s.exp_error));
        chk($sformatf("sc%0d_err_step", idx), 32'(err_step_o), 32'(s.exp_err_step));
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (dmi_req_valid_o) extra++;
        end
        chk($sformatf("sc%0d_no_extra_req", idx), 32'(extra), 32'd0);
        chk($sformatf("sc%0d_done_sticky", idx), 32'(done_o), 32'(s.exp_done));
        cur_stall_step = NO_STEP;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(dmi_req_valid_o), 32'd0);
        chk({tag, "_addr"}, 32'(dmi_req_addr_o), 32'd0);
        chk({tag, "_op"}, 32'(dmi_req_op_o), 32'd0);
        chk({tag, "_data"}, dmi_req_data_o, 32'd0);
        chk({tag, "_resp_ready"}, 32'(dmi_resp_ready_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
        chk({tag, "_error"}, 32'(error_o), 32'd0);
        chk({tag, "_err_step"}, 32'(err_step_o), 32'd0);
    endtask

    initial begin
        txn_t t;
        bit   ok;
        int   extra;

        //          halt abs  cerr ack  errst    stall      cyc done err estep
        tbl[0] = '{0,   0,   0,   0,   NO_STEP, NO_STEP,   0,  1,   0,  0};
        tbl[1] = '{0,   0,   0,   0,   NO_STEP, 2,         5,  1,   0,  0};
        tbl[2] = '{3,   0,   0,   0,   NO_STEP, NO_STEP,   0,  1,   0,  0};
        tbl[3] = '{100, 0,   0,   0,   NO_STEP, NO_STEP,   0,  0,   1,  3};
        tbl[4] = '{0,   2,   2,   0,   NO_STEP, NO_STEP,   0,  0,   1,  7};
        tbl[5] = '{0,   1,   0,   2,   NO_STEP, 5,         2,  1,   0,  0};
        tbl[6] = '{0,   0,   0,   0,   5,       NO_STEP,   0,  0,   1,  5};
        tbl[7] = '{0,   0,   0,   100, NO_STEP, NO_STEP,   0,  0,   1,  9};
        tbl[8] = '{0,   7,   0,   0,   NO_STEP, NO_STEP,   0,  1,   0,  0};
        tbl[9] = '{7,   0,   0,   0,   NO_STEP, NO_STEP,   0,  1,   0,  0};

        rst_i = 1'b1;
        start_i = 1'b0;
        dmi_req_ready_i = 1'b0;
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i = 32'd0;
        dmi_resp_resp_i = 2'd0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);
        chk("idle_resp_ready", 32'(dmi_resp_ready_o), 32'd0);

        for (int i = 0; i < 10; i++) run_scenario(i);

        // Reset while waiting for the step 5 response; the response lands after reset.
        build_expected(tbl[0]);
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            serve_req(ok, t);
            if (ok) serve_resp(t);
        end
        serve_req(ok, t);
        chk("rst_mid_step", 32'(t.step), 32'd5);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk_all_zero("rst_mid");
        dmi_resp_valid_i = 1'b1;
        dmi_resp_data_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        dmi_resp_valid_i = 1'b0;
        dmi_resp_data_i  = 32'd0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (dmi_req_valid_o || busy_o) extra++;
        end
        chk("rst_stays_idle", 32'(extra), 32'd0);
        exp_q.delete();

        // Reset and start in the same cycle: reset wins.
        rst_i = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        start_i = 1'b0;
        chk("rst_start_busy", 32'(busy_o), 32'd0);
        chk("rst_start_valid", 32'(dmi_req_valid_o), 32'd0);
        @(negedge clk);
        chk("rst_start_valid2", 32'(dmi_req_valid_o), 32'd0);

        run_scenario(0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
